// File: rtl/riscv_pkg.sv
// Shared types for the data-memory responder: FSM states, request bundle and
// the address-legality check used at commit time.
package riscv_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_BE_W = 4;

  typedef struct packed {
    logic [31:0]          addr;
    logic                 we;
    logic [DMEM_BE_W-1:0] be;
    logic [31:0]          wdata;
  } dmem_req_t;

  // Misaligned byte address, or any bit set above the word-addressed capacity.
  function automatic logic dmem_addr_err(input logic [31:0] addr, input int addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/riscv_sram_1rw.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
// Each byte lane is its own array so the tools map it onto byte-wide block RAM.
module riscv_sram_1rw
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [DMEM_BE_W-1:0] be,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    for (genvar gi = 0; gi < DMEM_BE_W; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rdata_reg;

      // Read data only changes on a read, so it holds across stores and idle cycles.
      always_ff @(posedge clk) begin
        if (en) begin
          if (we) begin
            if (be[gi]) begin
              mem[addr] <= wdata[8*gi +: 8];
            end
          end else begin
            rdata_reg <= mem[addr];
          end
        end
      end

      assign rdata[8*gi +: 8] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/riscv_dmem_responder.sv
// Responder side of the core's data-memory port: valid/ready request, programmable
// wait states, then a held response carrying load data or an address error.
module riscv_dmem_responder
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic                 req_we,
  input  logic [DMEM_BE_W-1:0] req_be,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state_reg, state_next;
  logic [3:0]  cnt_reg;
  dmem_req_t   req_reg;
  dmem_req_t   in_req;
  dmem_req_t   commit_req;
  logic        err_reg;
  logic        load_reg;
  logic        accept;
  logic        enter_resp;
  logic        commit_err;
  logic [31:0] sram_rdata;

  assign in_req    = '{addr: req_addr, we: req_we, be: req_be, wdata: req_wdata};
  assign req_ready = (state_reg == DM_IDLE);
  assign accept    = req_ready && req_valid;

  always_comb begin
    state_next = state_reg;
    enter_resp = 1'b0;
    case (state_reg)
      DM_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = DM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = DM_WAIT;
          end
        end
      end
      DM_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = DM_RESP;
          enter_resp = 1'b1;
        end
      end
      DM_RESP: begin
        if (rsp_ready) begin
          state_next = DM_IDLE;
        end
      end
      default: state_next = DM_IDLE;
    endcase
  end

  // With no wait states the access commits on the accept edge, before req_reg is loaded.
  assign commit_req = (WAIT_CYCLES == 0) ? in_req : req_reg;
  assign commit_err = dmem_addr_err(commit_req.addr, ADDR_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DM_IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        req_reg <= in_req;
        cnt_reg <= CNT_INIT;
      end else if (state_reg == DM_WAIT && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (enter_resp) begin
        err_reg  <= commit_err;
        load_reg <= !commit_req.we && !commit_err;
      end else if (state_reg == DM_RESP && rsp_ready) begin
        err_reg  <= 1'b0;
        load_reg <= 1'b0;
      end
    end
  end

  // Reset wins over a commit landing on the same edge, so a dropped store never writes.
  riscv_sram_1rw #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk   (clk),
    .en    (enter_resp && !commit_err && !rst),
    .we    (commit_req.we),
    .be    (commit_req.be),
    .addr  (commit_req.addr[ADDR_W+1:2]),
    .wdata (commit_req.wdata),
    .rdata (sram_rdata)
  );

  assign rsp_valid = (state_reg == DM_RESP);
  assign rsp_err   = err_reg;
  assign rsp_rdata = load_reg ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Self-checking bench: three responders (1, 3 and 0 wait states) driven by directed
// transactions, checked every cycle against a transaction-level memory model.
module tb_riscv_dmem_responder;

  localparam int N = 3;
  localparam int WC [N] = '{1, 3, 0};

  logic        clk = 1'b0;
  logic        rst       [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic [31:0] req_addr  [N];
  logic        req_we    [N];
  logic [3:0]  req_be    [N];
  logic [31:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      riscv_dmem_responder #(
        .ADDR_W      (10),
        .WAIT_CYCLES (WC[gi])
      ) u_dut (
        .clk       (clk),
        .rst       (rst[gi]),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_addr  (req_addr[gi]),
        .req_we    (req_we[gi]),
        .req_be    (req_be[gi]),
        .req_wdata (req_wdata[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  // Model: one outstanding request per instance, committed when its response is due.
  int          cyc = 0;
  logic        m_busy  [N];
  int          m_due   [N];
  logic [31:0] m_addr  [N];
  logic        m_we    [N];
  logic [3:0]  m_be    [N];
  logic [31:0] m_wdata [N];
  logic        m_err   [N];
  logic [31:0] m_rdata [N];
  logic [31:0] m_mem   [N][1024];

  task automatic check32(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic check1(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d: got %b expected %b", name, i, cyc, act, exp);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst[i] === 1'b1) begin
          m_busy[i] = 1'b0;
        end else if (!m_busy[i] && req_valid[i] === 1'b1) begin
          m_busy[i]  = 1'b1;
          m_addr[i]  = req_addr[i];
          m_we[i]    = req_we[i];
          m_be[i]    = req_be[i];
          m_wdata[i] = req_wdata[i];
          m_due[i]   = cyc + WC[i] + 1;
        end else if (m_busy[i] && cyc >= m_due[i] && rsp_ready[i] === 1'b1) begin
          m_busy[i] = 1'b0;
        end
        if (m_busy[i] && cyc + 1 == m_due[i]) begin
          logic [31:0] a;
          a = m_addr[i];
          m_err[i]   = (a % 4 != 0) || (a >= 32'h1000);
          m_rdata[i] = 32'd0;
          if (!m_err[i]) begin
            if (m_we[i]) begin
              for (int b = 0; b < 4; b++)
                if (m_be[i][b]) m_mem[i][a / 4][8*b +: 8] = m_wdata[i][8*b +: 8];
            end else begin
              m_rdata[i] = m_mem[i][a / 4];
            end
          end
        end
      end
      cyc++;
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst[i] === 1'b0) begin
          logic exp_v;
          exp_v = m_busy[i] && cyc >= m_due[i];
          check1("req_ready", i, req_ready[i], !m_busy[i]);
          check1("rsp_valid", i, rsp_valid[i], exp_v);
          if (exp_v) begin
            check32("rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
            check1("rsp_err", i, rsp_err[i], m_err[i]);
          end
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic transact(input int i, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata, input int hold,
                          input logic poke, output logic [31:0] rd, output logic er,
                          output int lat);
    int t;
    rd = 32'd0;
    er = 1'b0;
    lat = 0;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_be[i]    = be;
    req_wdata[i] = wdata;
    t = 0;
    while (req_ready[i] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      check1("accept_timeout", i, 1'b0, 1'b1);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs after accept; they must be ignored from here on.
    req_valid[i] = poke;
    req_we[i]    = ~we;
    req_addr[i]  = $urandom;
    req_be[i]    = ~be;
    req_wdata[i] = ~wdata;
    lat = 1;
    if (rsp_valid[i] !== 1'b1) rsp_ready[i] = poke;
    while (rsp_valid[i] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rsp_ready[i] = 1'b0;
    req_valid[i] = 1'b0;
    if (lat == 40) begin
      check1("rsp_timeout", i, 1'b0, 1'b1);
      return;
    end
    repeat (hold) @(negedge clk);
    rd = rsp_rdata[i];
    er = rsp_err[i];
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    $display("txn inst%0d we=%0d addr=%h be=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             i, we, addr, be, wdata, rd, er, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      req_valid[i] = 1'b0;
      req_addr[i] = 32'd0;
      req_we[i] = 1'b0;
      req_be[i] = 4'h0;
      req_wdata[i] = 32'd0;
      rsp_ready[i] = 1'b0;
      m_busy[i] = 1'b0;
      m_due[i] = 0;
      m_err[i] = 1'b0;
      m_rdata[i] = 32'd0;
    end
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0;
      check1("reset_req_ready", i, req_ready[i], 1'b1);
      check1("reset_rsp_valid", i, rsp_valid[i], 1'b0);
      check32("reset_rsp_rdata", i, rsp_rdata[i], 32'd0);
      check1("reset_rsp_err", i, rsp_err[i], 1'b0);
    end

    // Full-word store then load, one wait state.
    transact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 1'b0, rd, er, lat);
    check32("t1_store_lat", 0, 32'(lat), 32'd2);
    check1("t1_store_err", 0, er, 1'b0);
    check32("t1_store_rdata", 0, rd, 32'd0);
    transact(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b1, rd, er, lat);
    check32("t1_load_rdata", 0, rd, 32'hDEADBEEF);
    check32("t1_load_lat", 0, 32'(lat), 32'd2);

    // Single-byte store merges into existing word.
    transact(0, 1'b1, 32'h10, 4'b0010, 32'h0000_5500, 0, 1'b0, rd, er, lat);
    transact(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b0, rd, er, lat);
    check32("t2_merge_rdata", 0, rd, 32'hDEAD55EF);

    // Error responses and no side effects.
    transact(0, 1'b0, 32'h13, 4'h0, 32'h0, 0, 1'b0, rd, er, lat);
    check1("t3_misalign_err", 0, er, 1'b1);
    check32("t3_misalign_rdata", 0, rd, 32'd0);
    check32("t3_misalign_lat", 0, 32'(lat), 32'd2);
    transact(0, 1'b1, 32'h0, 4'hF, 32'h11223344, 0, 1'b0, rd, er, lat);
    transact(0, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 0, 1'b0, rd, er, lat);
    check1("t3_range_err", 0, er, 1'b1);
    transact(0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, rd, er, lat);
    check32("t3_range_unchanged", 0, rd, 32'h11223344);
    transact(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 0, 1'b0, rd, er, lat);
    check1("t3_be0_err", 0, er, 1'b0);
    transact(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b0, rd, er, lat);
    check32("t3_be0_unchanged", 0, rd, 32'hDEAD55EF);

    // Backpressure: response held five cycles.
    transact(0, 1'b0, 32'h10, 4'h0, 32'h0, 5, 1'b0, rd, er, lat);
    check32("t4_hold_rdata", 0, rd, 32'hDEAD55EF);
    check1("t4_after_req_ready", 0, req_ready[0], 1'b1);

    // Reset while a store sits in WAIT with cnt==1.
    transact(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 0, 1'b0, rd, er, lat);
    check32("t5_lat", 1, 32'(lat), 32'd4);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h20;
    req_be[1]    = 4'hF;
    req_wdata[1] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check1("t5_rst_rsp_valid", 1, rsp_valid[1], 1'b0);
    check1("t5_rst_req_ready", 1, req_ready[1], 1'b1);
    repeat (4) @(negedge clk);
    transact(1, 1'b0, 32'h20, 4'h0, 32'h0, 0, 1'b1, rd, er, lat);
    check32("t5_prior_value", 1, rd, 32'hCAFEF00D);

    // Zero wait states: directed, then random against the model.
    transact(2, 1'b1, 32'h40, 4'hF, 32'hA5A55A5A, 0, 1'b0, rd, er, lat);
    transact(2, 1'b0, 32'h40, 4'h0, 32'h0, 0, 1'b0, rd, er, lat);
    check32("t6_lat", 2, 32'(lat), 32'd1);
    check32("t6_rdata", 2, rd, 32'hA5A55A5A);
    for (int w = 0; w < 8; w++)
      transact(2, 1'b1, 32'(w * 4), 4'hF, $urandom, 0, 1'b0, rd, er, lat);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 7) * 4);
      case ($urandom_range(0, 7))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | 32'h0000_1000;
        default: ;
      endcase
      transact(2, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rd, er, lat);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
